// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage stall/bubble generation with deferred
// flush handling, saturating stall-origin counters and a front-end watchdog.
module pipe_ctrl #(
  parameter int NSTAGE     = 5,
  parameter int SW         = $clog2(NSTAGE),
  parameter int CNT_W      = 32,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              flush_req,
  input  logic [SW-1:0]     flush_src,
  input  logic [SW-1:0]     cnt_sel,
  input  logic              cnt_clr,
  input  logic              wdog_clr,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              flush_pend,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              deadlock
);

  localparam logic [SW:0]       NSTAGE_EXT = (SW+1)'(NSTAGE);
  localparam logic [WDOG_W-1:0] WDOG_MAX   = WDOG_W'(WDOG_LIMIT);

  logic [NSTAGE-1:0] raw_stall;
  logic [SW-1:0]     orig_idx;
  logic              any_stall;

  logic              new_valid;
  logic              cand_valid;
  logic [SW-1:0]     cand_src;
  logic              fire;
  logic [NSTAGE-1:0] flush_mask;
  logic [NSTAGE-1:0] stall_int;

  logic              pend_valid;
  logic [SW-1:0]     pend_src;

  logic [CNT_W-1:0]  cnt_q [NSTAGE];
  logic [WDOG_W-1:0] wcnt;
  logic              deadlock_q;

  // Every stage at or below the oldest requester is held.
  always_comb begin
    logic acc;
    raw_stall = '0;
    acc       = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc          = acc | stall_req[i];
      raw_stall[i] = acc;
    end
  end

  always_comb begin
    orig_idx = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_req[i]) begin
        orig_idx = SW'(i);
      end
    end
  end

  assign any_stall = |stall_req;

  // The older of a new and a waiting redirect wins.
  always_comb begin
    new_valid  = flush_req && ({1'b0, flush_src} < NSTAGE_EXT);
    cand_valid = new_valid || pend_valid;
    cand_src   = pend_src;
    if (new_valid && pend_valid) begin
      cand_src = (flush_src > pend_src) ? flush_src : pend_src;
    end else if (new_valid) begin
      cand_src = flush_src;
    end
  end

  assign fire = cand_valid && !raw_stall[cand_src];

  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      flush_mask[i] = fire && (SW'(i) < cand_src);
    end
  end

  assign stall_int = raw_stall & ~flush_mask;

  always_comb begin
    stall = '0;
    flush = '0;
    if (!rst) begin
      stall = stall_int;
      flush = flush_mask;
    end
  end

  // A blocked candidate waits here until its target stage stops stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_src   <= '0;
    end else if (cand_valid && !fire) begin
      pend_valid <= 1'b1;
      pend_src   <= cand_src;
    end else begin
      pend_valid <= 1'b0;
      pend_src   <= '0;
    end
  end

  assign flush_pend = pend_valid;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSTAGE; i++) begin
      if (rst || cnt_clr) begin
        cnt_q[i] <= '0;
      end else if (any_stall && (orig_idx == SW'(i)) && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_data = '0;
    if (!rst && ({1'b0, cnt_sel} < NSTAGE_EXT)) begin
      cnt_data = cnt_q[cnt_sel];
    end
  end

  // Watchdog tracks consecutive cycles with the fetch stage held.
  always_ff @(posedge clk) begin
    if (rst || wdog_clr) begin
      wcnt       <= '0;
      deadlock_q <= 1'b0;
    end else if (stall_int[0]) begin
      if (wcnt != WDOG_MAX) begin
        wcnt <= wcnt + WDOG_W'(1);
        if (wcnt == WDOG_MAX - WDOG_W'(1)) begin
          deadlock_q <= 1'b1;
        end
      end
    end else begin
      wcnt <= '0;
    end
  end

  assign deadlock = deadlock_q;

endmodule
